sparsity_scan: RTL
==================

Name: sparsity_scan

Overview:
Parametrised successor to the single-tile sparsity flag reader. Walks NUM_BLOCK blocks of a flag tile and skips any block whose bit in valid_mask is 0 without issuing a memory read. Reads the 1-bit flags of each valid block from an external synchronous flag RAM, with optional replay of each block's last element for row padding. Emits the flags as a valid/ready stream to the PE-array sparsity controller, and reports the skipped-block count and completion.

Parameters:
BLOCK_W, 10, flag elements per block (>=2)
NUM_BLOCK, 16, blocks per tile
ADDR_WIDTH, 8, flag RAM address width; NUM_BLOCK*BLOCK_W <= 2**ADDR_WIDTH
PAD_EN, 1, 1 = replay the last element of each valid block once (row padding); 0 = no replay
BLK_WIDTH, 4, block index width, clog2(NUM_BLOCK)
CNT_WIDTH, 5, skip counter width, clog2(NUM_BLOCK+1)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
clk_en  input  1  global enable; when low, all state and outputs hold
start  input  1  begin a tile scan; accepted only in IDLE
valid_mask  input  NUM_BLOCK  per-block valid bits, latched on accepted start
mem_rd_req  output  1  flag RAM read strobe
mem_rd_addr  output  ADDR_WIDTH  flag RAM read address
mem_rd_data  input  1  flag RAM data, valid the cycle after mem_rd_req
out_valid  output  1  stream data valid
out_ready  input  1  stream consumer ready
out_flag  output  1  flag value
out_addr  output  ADDR_WIDTH  RAM address the flag came from
out_block  output  BLK_WIDTH  block index of the flag
out_pad  output  1  1 = padded replay element
out_last  output  1  last element of the tile
skip_cnt  output  CNT_WIDTH  number of masked blocks skipped in the current or last scan
busy  output  1  high whenever the FSM is not in IDLE
done  output  1  one-cycle pulse on scan completion

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; latched mask 0; internal block index, offset and pad_pass 0.
- clk_en=0 freezes the FSM, all counters and all registered outputs.
  - mem_rd_req is forced 0 while clk_en=0. A read already issued is completed by capturing mem_rd_data in the next enabled cycle.
  - The flag RAM must hold its output while clk_en=0.
- FSM states: IDLE, CHECK, READ, EMIT, FIN.
- IDLE:
  - start=1 latches valid_mask, clears skip_cnt, sets b=0, goes to CHECK.
  - start in any other state is ignored.
- CHECK (one cycle per block):
  - mask[b]=0: skip_cnt+1. If b=NUM_BLOCK-1 go to FIN, else b+1 and stay in CHECK.
  - mask[b]=1: offset=0, pad_pass=0, go to READ.
- READ: mem_rd_req=1 for one cycle, mem_rd_addr = b*BLOCK_W + offset; go to EMIT.
- EMIT:
  - Register out_flag from mem_rd_data in the first EMIT cycle; assert out_valid.
  - out_flag, out_addr, out_block, out_pad and out_last are held stable while out_valid=1 and out_ready=0.
  - Transfer occurs when out_valid & out_ready. On the cycle after a transfer, out_valid drops to 0.
- Advance after a transfer:
  - offset<BLOCK_W-1: offset+1, go to READ.
  - offset=BLOCK_W-1, PAD_EN=1, pad_pass=0: pad_pass=1, offset unchanged, go to READ. This re-reads the same address, and the emitted element has out_pad=1.
  - Otherwise the block is finished. If b=NUM_BLOCK-1 go to FIN, else b+1 and go to CHECK.
- out_last=1 only on the final element of the final valid block, i.e. no higher-indexed block in the mask is valid. With PAD_EN=1 this is the padded replay element.
- FIN: done=1 for one cycle, then IDLE. busy is 0 from IDLE onward, and skip_cnt holds its value until the next start.
- All-zero mask: the scan takes NUM_BLOCK CHECK cycles plus FIN. There is no read and no out_valid. skip_cnt=NUM_BLOCK and out_last is never asserted.
- Latency: start accepted at cycle 0; first out_valid at cycle 3 when block 0 is valid. Each element takes 2 cycles plus consumer stall cycles.
- Elements emitted per valid block: BLOCK_W+PAD_EN.
- Address arithmetic: ADDR_WIDTH unsigned, no wrap permitted by the parameter constraint.
- Asynchronous reset mid-scan returns the block to IDLE immediately and drops out_valid; no done pulse is produced.

Test Plan:
(Tests use BLOCK_W=4, NUM_BLOCK=4, PAD_EN=1.)
1. Full mask: valid_mask=4'b1111, out_ready=1, RAM flag[a]=a[0] -> 20 elements in order. Addresses per block are 4b,4b+1,4b+2,4b+3,4b+3, with out_pad=1 on the 5th element. out_last only on the element at addr 15 with pad=1. done pulse; skip_cnt=0.
2. Sparse mask: valid_mask=4'b0101 -> only blocks 0 and 2 are emitted, with 10 elements. No mem_rd_addr in 4..7 or 12..15. out_last on addr 11 pad. skip_cnt=2.
3. Empty mask: valid_mask=0 -> no mem_rd_req and no out_valid. done exactly 6 cycles after start is accepted; skip_cnt=4.
4. Backpressure: out_ready held 0 for 5 cycles at element 2 -> outputs stable for all 5 cycles, no new mem_rd_req, and the stream is otherwise identical to test 1.
5. PAD_EN=0 with clk_en toggling 1/0 every cycle -> 16 elements, none padded, identical sequence to an always-enabled run.
6. start pulsed while busy, and rst_n asserted mid-block 1 -> the second start is ignored. After reset all outputs are 0 and busy=0; a new start scans from block 0.

Source files
------------

// File: rtl/sparsity_scan.sv
// Tile sparsity-flag scanner: walks the blocks of a flag tile, skips masked-off blocks,
// reads each valid block's flags from a 1-cycle synchronous RAM and streams them out.
module sparsity_scan #(
  parameter int BLOCK_W    = 10,
  parameter int NUM_BLOCK  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int PAD_EN     = 1,
  parameter int BLK_WIDTH  = 4,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  start,
  input  logic [NUM_BLOCK-1:0]  valid_mask,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_flag,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [BLK_WIDTH-1:0]  out_block,
  output logic                  out_pad,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  skip_cnt,
  output logic                  busy,
  output logic                  done
);

  localparam int OFF_W = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
  localparam logic [OFF_W-1:0]     LAST_OFF = OFF_W'(BLOCK_W - 1);
  localparam logic [BLK_WIDTH-1:0] LAST_BLK = BLK_WIDTH'(NUM_BLOCK - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_EMIT, S_FIN} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [NUM_BLOCK-1:0]   r_mask;
  logic [BLK_WIDTH-1:0]   r_blk;
  logic [OFF_W-1:0]       r_off;
  logic                   r_pad;
  logic [CNT_WIDTH-1:0]   r_skip;
  logic                   r_flag;
  logic                   r_hold;
  logic                   r_done;

  logic                   w_xfer;
  logic                   w_elem_more;
  logic                   w_blk_last;
  logic [NUM_BLOCK-1:0]   w_above;
  logic [ADDR_WIDTH-1:0]  w_addr;

  assign w_xfer      = (r_state == S_EMIT) && out_ready;
  // The padded replay pass is the one extra element per block when PAD_EN is set.
  assign w_elem_more = (r_off != LAST_OFF) || ((PAD_EN != 0) && !r_pad);
  assign w_blk_last  = (r_blk == LAST_BLK);
  assign w_above     = (r_mask >> r_blk) >> 1;
  assign w_addr      = ADDR_WIDTH'(r_blk) * ADDR_WIDTH'(BLOCK_W) + ADDR_WIDTH'(r_off);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (clk_en) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CHECK;
      S_CHECK: begin
        if (r_mask[r_blk])   w_next = S_READ;
        else if (w_blk_last) w_next = S_FIN;
      end
      S_READ:  w_next = S_EMIT;
      S_EMIT: begin
        if (w_xfer) begin
          if (w_elem_more)     w_next = S_READ;
          else if (w_blk_last) w_next = S_FIN;
          else                 w_next = S_CHECK;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    out_valid  = (r_state == S_EMIT);
    mem_rd_req = (r_state == S_READ) && clk_en;
    // RAM data is live only in the first EMIT cycle; afterwards the captured copy is shown.
    out_flag   = r_flag;
    if ((r_state == S_EMIT) && !r_hold) out_flag = mem_rd_data;
    out_last   = out_valid && !w_elem_more && !(|w_above);
  end

  assign mem_rd_addr = w_addr;
  assign out_addr    = w_addr;
  assign out_block   = r_blk;
  assign out_pad     = r_pad;
  assign skip_cnt    = r_skip;
  assign done        = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
      r_blk  <= '0;
      r_off  <= '0;
      r_pad  <= 1'b0;
      r_skip <= '0;
      r_flag <= 1'b0;
      r_hold <= 1'b0;
      r_done <= 1'b0;
    end else if (clk_en) begin
      r_done <= (r_state == S_FIN);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mask <= valid_mask;
            r_skip <= '0;
            r_blk  <= '0;
          end
        end
        S_CHECK: begin
          if (r_mask[r_blk]) begin
            r_off <= '0;
            r_pad <= 1'b0;
          end else begin
            r_skip <= r_skip + 1'b1;
            if (!w_blk_last) r_blk <= r_blk + 1'b1;
          end
        end
        S_READ: r_hold <= 1'b0;
        S_EMIT: begin
          if (!r_hold) begin
            r_flag <= mem_rd_data;
            r_hold <= 1'b1;
          end
          if (w_xfer) begin
            if (r_off != LAST_OFF)              r_off <= r_off + 1'b1;
            else if ((PAD_EN != 0) && !r_pad)   r_pad <= 1'b1;
            else if (!w_blk_last)               r_blk <= r_blk + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
